// File: rtl/pc_call_control.sv
// Next-PC selection for the fetch stage, plus push/pop control and occupancy
// tracking for the downstream return-address stack.
module pc_call_control #(
   parameter int ADDR_W      = 12,
   parameter int STACK_DEPTH = 8,
   parameter int DEPTH_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              call,
   input  logic [ADDR_W-1:0] call_target,
   input  logic              ret,
   input  logic [ADDR_W-1:0] ret_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              push,
   output logic              pop,
   output logic [ADDR_W-1:0] push_data,
   output logic [DEPTH_W-1:0] depth,
   output logic              overflow,
   output logic              underflow,
   output logic              flush
);

   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
   localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);

   logic [ADDR_W-1:0]  pc_reg;
   logic [ADDR_W-1:0]  pc_next;
   logic [ADDR_W-1:0]  pc_inc;
   logic [DEPTH_W-1:0] depth_reg;
   logic [DEPTH_W-1:0] depth_next;
   logic               overflow_reg;
   logic               overflow_next;
   logic               underflow_reg;
   logic               underflow_next;
   logic               flush_reg;
   logic               flush_next;

   // Natural ADDR_W-bit wrap gives 0xFFF -> 0x000.
   assign pc_inc = pc_reg + PC_ONE;

   always_comb begin
      pc_next        = pc_inc;
      depth_next     = depth_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      flush_next     = 1'b0;
      push           = 1'b0;
      pop            = 1'b0;
      if (reset) begin
         pc_next = '0;
      end else if (stall) begin
         pc_next = pc_reg;
      end else if (branch_taken) begin
         pc_next    = branch_target;
         flush_next = 1'b1;
      end else if (ret) begin
         // An empty-stack return falls through sequentially and is not a redirect.
         if (depth_reg != '0) begin
            pc_next    = ret_addr;
            pop        = 1'b1;
            depth_next = depth_reg - DEPTH_ONE;
            flush_next = 1'b1;
         end else begin
            underflow_next = 1'b1;
         end
      end else if (call) begin
         pc_next    = call_target;
         flush_next = 1'b1;
         if (depth_reg != DEPTH_FULL) begin
            push       = 1'b1;
            depth_next = depth_reg + DEPTH_ONE;
         end else begin
            overflow_next = 1'b1;
         end
      end else if (jump) begin
         pc_next    = jump_target;
         flush_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg        <= '0;
         depth_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         flush_reg     <= 1'b0;
      end else begin
         pc_reg        <= pc_next;
         depth_reg     <= depth_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
         flush_reg     <= flush_next;
      end
   end

   assign pc        = pc_reg;
   assign push_data = pc_inc;
   assign depth     = depth_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
   assign flush     = flush_reg;

endmodule

// File: doc/pc_call_control.md
Name: pc_call_control

Overview:
- Program-counter sequencing stage for the fetch end of the pipelined MIPS core.
- Selects the next 12-bit PC from sequential, branch, jump, call and return sources.
- Drives the push, pop and data inputs of the 8-entry return-address stack that sits directly downstream, and takes the return address from that stack's data output.
- Tracks stack occupancy, so the block never issues a push to a full stack or a pop from an empty one. It flags either attempt with a sticky error bit and signals a fetch flush after every redirect.

Parameters:
ADDR_W, 12, PC and return-address width
STACK_DEPTH, 8, capacity of the downstream return-address stack
DEPTH_W, 4, occupancy counter width (must hold 0..STACK_DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and suppress all stack traffic this cycle
branch_taken  input  1  taken conditional branch
branch_target  input  ADDR_W  branch destination
jump  input  1  unconditional jump
jump_target  input  ADDR_W  jump destination
call  input  1  subroutine call
call_target  input  ADDR_W  call destination
ret  input  1  subroutine return
ret_addr  input  ADDR_W  top-of-stack value from the return-address stack (valid combinationally)
pc  output  ADDR_W  current fetch address (registered)
push  output  1  stack push strobe (combinational)
pop  output  1  stack pop strobe (combinational)
push_data  output  ADDR_W  return address to push, equal to pc+1
depth  output  DEPTH_W  current stack occupancy (registered)
overflow  output  1  sticky: a call was made with the stack full
underflow  output  1  sticky: a return was made with the stack empty
flush  output  1  registered, one-cycle pulse after a non-sequential redirect

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous and active-high. Port names are clk and reset.
- On reset the registered outputs are pc=0, depth=0, overflow=0, underflow=0 and flush=0.
- push and pop are forced to 0 during any cycle in which reset is high.

Source priority (evaluated each cycle with reset=0 and stall=0; the highest-priority asserted source wins):
1. branch_taken: pc <= branch_target.
2. ret:
   - If depth>0: pc <= ret_addr, pop=1, depth <= depth-1.
   - If depth==0: pc <= pc+1, pop=0, underflow <= 1.
3. call:
   - If depth<STACK_DEPTH: pc <= call_target, push=1, depth <= depth+1.
   - If depth==STACK_DEPTH: pc <= call_target, push=0, overflow <= 1.
4. jump: pc <= jump_target.
5. Otherwise (sequential): pc <= pc+1.

Combinational outputs and interaction with the stack:
- push_data = pc+1 at all times. The stack captures it on the same edge on which pc updates.
- push and pop are never both 1.
- At most one stack operation occurs per cycle.
- Sources of lower priority than the winner are ignored, with no stack side effects.

Arithmetic:
- pc+1 wraps modulo 2^ADDR_W, so 0xFFF becomes 0x000.
- depth never leaves the range 0..STACK_DEPTH.

Stall:
- pc, depth and the sticky flags hold their values.
- push and pop are 0.
- flush is 0 on the following cycle.

Flush:
- flush <= 1 on the edge after any cycle in which pc was loaded from branch_target, ret_addr, call_target or jump_target. Otherwise flush <= 0.
- A return on an empty stack (underflow) does not count as a redirect.
- Back-to-back redirects give consecutive flush pulses.

Sticky flags:
- overflow and underflow clear only on reset.
- Once set, they do not alter any other behaviour.

Latency:
- The new pc is visible one cycle after the control input is sampled.
- Stack strobes are issued in the same cycle as the control input.

Reset during operation:
- Reset overrides stall and every control input.
- A push or pop coincident with reset is not issued.

Test Plan:
- Reset, then 5 free-running cycles -> pc steps 0,1,2,3,4,5; push=pop=0; flush=0; depth=0.
- At pc=0x010, assert call with call_target=0x100 for one cycle -> in that cycle push=1 and push_data=0x011. Next cycle pc=0x100, depth=1, flush=1. Later, ret with ret_addr=0x011 -> pop=1; next pc=0x011, depth=0.
- Nine consecutive calls from depth 0 -> pushes 1-8 are issued and depth reaches 8. On the ninth, push=0, overflow=1, pc=call_target and depth stays 8.
- ret with depth=0 at pc=0x020 -> pop=0, underflow=1, next pc=0x021, no flush.
- Same cycle: branch_taken (target 0x200), call and ret with depth=2 -> pc=0x200, push=pop=0, depth stays 2. A stall asserted alongside call -> pc holds, push=0.
- pc=0xFFF sequential -> next pc=0x000. Reset asserted in the same cycle as a call at depth 3 -> push=0, and next cycle pc=0, depth=0, flags=0.
